// File: rtl/pc_fetch_if.sv
// pc_fetch_if: instruction-memory request/response bus between the fetch sequencer (master) and imem (slave)
interface pc_fetch_if #(parameter int XLEN = 32) ();
    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_addr;
    logic            rsp_valid;
    logic [XLEN-1:0] rsp_data;
    modport master (output req_valid, req_addr, input req_ready, rsp_valid, rsp_data);
    modport slave (input req_valid, req_addr, output req_ready, rsp_valid, rsp_data);
endinterface

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: PC ownership and instruction fetch sequencing; optional MISALIGN_TRAP_EN traps misaligned targets
module pc_fetch_sequencer #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      pc_sel_i,
    input  logic [XLEN-1:0] jal_addr_i,
    input  logic [XLEN-1:0] branch_addr_i,
    input  logic [XLEN-1:0] jalr_addr_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_addr_i,
    input  logic            stall_i,
    input  logic            id_ready_i,
    pc_fetch_if.master      imem,
    output logic            if_valid_o,
    output logic [XLEN-1:0] if_pc_o,
    output logic [XLEN-1:0] if_instr_o,
    output logic            misalign_trap_o,
    output logic [XLEN-1:0] misalign_addr_o
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, TRAP} state_e;
    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, tgt, next_pc, redir, if_pc_q, if_instr_q;
    logic            kill_q, kill_d, if_valid_q, consume, mis;
    assign consume = id_ready_i & ~stall_i;
    assign redir   = redirect_addr_i & ~XLEN'(3);
    assign tgt     = pc_sel_i == 2'd0 ? pc_q + XLEN'(4) :
                     pc_sel_i == 2'd1 ? jal_addr_i :
                     pc_sel_i == 2'd2 ? branch_addr_i : jalr_addr_i & ~XLEN'(1);
`ifdef MISALIGN_TRAP_EN
    logic            mtrap_q;
    logic [XLEN-1:0] maddr_q;
    assign mis     = |tgt[1:0];
    assign next_pc = tgt;
    // Misalign trap pulse and sticky offending address
    always_ff @(posedge clk) begin
        if (rst) begin
            mtrap_q <= 1'b0;
            maddr_q <= '0;
        end else begin
            mtrap_q <= state_q == HOLD && consume && !redirect_valid_i && mis;
            if (state_q == HOLD && consume && !redirect_valid_i && mis) maddr_q <= tgt;
        end
    end
    assign misalign_trap_o = mtrap_q;
    assign misalign_addr_o = maddr_q;
`else
    assign mis             = 1'b0;
    assign next_pc         = tgt & ~XLEN'(3);
    assign misalign_trap_o = 1'b0;
    assign misalign_addr_o = '0;
`endif
    // State register together with PC and stale-response kill flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_VEC;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            kill_q  <= kill_d;
        end
    end
    // Next state: redirect beats consume; a redirect with an outstanding request arms kill
    always_comb begin
        state_d = state_q;
        kill_d  = kill_q;
        pc_d    = pc_q;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (imem.req_ready) state_d = WAIT;
                if (redirect_valid_i) kill_d = imem.req_ready;
            end
            WAIT: begin
                if (imem.rsp_valid) begin
                    state_d = redirect_valid_i || kill_q ? REQ : HOLD;
                    kill_d  = 1'b0;
                end else if (redirect_valid_i) kill_d = 1'b1;
            end
            HOLD: begin
                if (redirect_valid_i) state_d = REQ;
                else if (consume) state_d = mis ? TRAP : REQ;
            end
            TRAP: if (redirect_valid_i) state_d = REQ;
            default: state_d = IDLE;
        endcase
        if (state_q != IDLE && redirect_valid_i) pc_d = redir;
        else if (state_q == HOLD && consume && !mis) pc_d = next_pc;
    end
    // Output decode: request is presented only in REQ, at the current PC
    always_comb begin
        imem.req_valid = state_q == REQ;
        imem.req_addr  = pc_q;
    end
    // Decode-side registers: capture a live response, release on consume or redirect
    always_ff @(posedge clk) begin
        if (rst) begin
            if_valid_q <= 1'b0;
            if_pc_q    <= RESET_VEC;
            if_instr_q <= '0;
        end else if (state_q == WAIT && imem.rsp_valid && !kill_q && !redirect_valid_i) begin
            if_valid_q <= 1'b1;
            if_pc_q    <= pc_q;
            if_instr_q <= imem.rsp_data;
        end else if (state_q == HOLD && (redirect_valid_i || consume)) begin
            if_valid_q <= 1'b0;
        end
    end
    assign if_valid_o = if_valid_q;
    assign if_pc_o    = if_pc_q;
    assign if_instr_o = if_instr_q;
endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// tb_pc_fetch_sequencer: directed self-checking bench for pc_fetch_sequencer
module tb_pc_fetch_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  pc_sel = '0;
    logic [31:0] jal_addr = '0, branch_addr = '0, jalr_addr = '0, redirect_addr = '0;
    logic        redirect_valid = 1'b0, stall = 1'b0, id_ready = 1'b0;
    logic        if_valid, misalign_trap;
    logic [31:0] if_pc, if_instr, misalign_addr;
    int          n_chk = 0, n_fail = 0;
    pc_fetch_if bus ();
    pc_fetch_sequencer dut (
        .clk(clk), .rst(rst), .pc_sel_i(pc_sel), .jal_addr_i(jal_addr),
        .branch_addr_i(branch_addr), .jalr_addr_i(jalr_addr),
        .redirect_valid_i(redirect_valid), .redirect_addr_i(redirect_addr),
        .stall_i(stall), .id_ready_i(id_ready), .imem(bus),
        .if_valid_o(if_valid), .if_pc_o(if_pc), .if_instr_o(if_instr),
        .misalign_trap_o(misalign_trap), .misalign_addr_o(misalign_addr)
    );
    always #5 clk = ~clk;
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic fetch(input logic [31:0] addr, input logic [31:0] data);
        for (int i = 0; i < 8 && bus.req_valid !== 1'b1; i++) tick();
        chk("req_valid", {31'd0, bus.req_valid}, 32'd1);
        chk("req_addr", bus.req_addr, addr);
        bus.req_ready = 1'b1;
        tick();
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b1;
        bus.rsp_data  = data;
        tick();
        bus.rsp_valid = 1'b0;
        chk("if_valid", {31'd0, if_valid}, 32'd1);
        chk("if_pc", if_pc, addr);
        chk("if_instr", if_instr, data);
    endtask
    task automatic consume(input logic [1:0] sel);
        pc_sel   = sel;
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
        chk("if_valid_drop", {31'd0, if_valid}, 32'd0);
    endtask
    initial begin
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_data  = '0;
        repeat (3) tick();
        chk("rst_req_valid", {31'd0, bus.req_valid}, 32'd0);
        chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_if_instr", if_instr, 32'h0);
        chk("rst_mtrap", {31'd0, misalign_trap}, 32'd0);
        chk("rst_maddr", misalign_addr, 32'h0);
        rst = 1'b0;
        fetch(32'h0, 32'h0000_0013);
        jal_addr = 32'h100;
        consume(2'd1);
        fetch(32'h100, 32'h1111_1111);
        branch_addr = 32'h80;
        consume(2'd2);
        fetch(32'h80, 32'h2222_2222);
        jalr_addr = 32'h205;
        consume(2'd3);
        fetch(32'h204, 32'h3333_3333);
        jal_addr = 32'hFFFF_FFFC;
        consume(2'd1);
        fetch(32'hFFFF_FFFC, 32'h4444_4444);
        consume(2'd0);
        fetch(32'h0, 32'h5555_5555);
        stall    = 1'b1;
        id_ready = 1'b1;
        pc_sel   = 2'd0;
        repeat (4) begin
            tick();
            chk("stall_if_valid", {31'd0, if_valid}, 32'd1);
            chk("stall_if_instr", if_instr, 32'h5555_5555);
            chk("stall_no_req", {31'd0, bus.req_valid}, 32'd0);
        end
        stall = 1'b0;
        tick();
        id_ready = 1'b0;
        fetch(32'h4, 32'h6666_6666);
        consume(2'd0);
        bus.req_ready = 1'b1;
        tick();
        bus.req_ready  = 1'b0;
        redirect_valid = 1'b1;
        redirect_addr  = 32'h1C0;
        tick();
        redirect_valid = 1'b0;
        chk("kill_wait_no_req", {31'd0, bus.req_valid}, 32'd0);
        bus.rsp_valid = 1'b1;
        bus.rsp_data  = 32'hDEAD_BEEF;
        tick();
        bus.rsp_valid = 1'b0;
        chk("stale_if_valid", {31'd0, if_valid}, 32'd0);
        chk("stale_req_addr", bus.req_addr, 32'h1C0);
        fetch(32'h1C0, 32'h7777_7777);
        consume(2'd0);
        bus.req_ready = 1'b1;
        tick();
        bus.req_ready  = 1'b0;
        bus.rsp_valid  = 1'b1;
        bus.rsp_data   = 32'hBAD0_0001;
        redirect_valid = 1'b1;
        redirect_addr  = 32'h300;
        tick();
        bus.rsp_valid  = 1'b0;
        redirect_valid = 1'b0;
        chk("redir_rsp_if_valid", {31'd0, if_valid}, 32'd0);
        chk("redir_rsp_addr", bus.req_addr, 32'h300);
        fetch(32'h300, 32'h8888_8888);
        pc_sel         = 2'd1;
        jal_addr       = 32'h500;
        id_ready       = 1'b1;
        redirect_valid = 1'b1;
        redirect_addr  = 32'h403;
        tick();
        id_ready       = 1'b0;
        redirect_valid = 1'b0;
        chk("redir_consume_if_valid", {31'd0, if_valid}, 32'd0);
        chk("redir_consume_addr", bus.req_addr, 32'h400);
        fetch(32'h400, 32'h9999_9999);
        consume(2'd0);
        bus.req_ready  = 1'b1;
        redirect_valid = 1'b1;
        redirect_addr  = 32'h600;
        tick();
        bus.req_ready  = 1'b0;
        redirect_valid = 1'b0;
        chk("req_hs_redir_wait", {31'd0, bus.req_valid}, 32'd0);
        bus.rsp_valid = 1'b1;
        bus.rsp_data  = 32'hBAD0_0002;
        tick();
        bus.rsp_valid = 1'b0;
        chk("req_hs_redir_if_valid", {31'd0, if_valid}, 32'd0);
        chk("req_hs_redir_addr", bus.req_addr, 32'h600);
        fetch(32'h600, 32'hAAAA_AAAA);
        jal_addr = 32'h102;
`ifdef MISALIGN_TRAP_EN
        consume(2'd1);
        chk("mtrap_pulse", {31'd0, misalign_trap}, 32'd1);
        chk("mtrap_addr", misalign_addr, 32'h102);
        chk("mtrap_no_req", {31'd0, bus.req_valid}, 32'd0);
        repeat (3) begin
            tick();
            chk("mtrap_clear", {31'd0, misalign_trap}, 32'd0);
            chk("mtrap_hold_no_req", {31'd0, bus.req_valid}, 32'd0);
        end
        chk("mtrap_addr_held", misalign_addr, 32'h102);
        redirect_valid = 1'b1;
        redirect_addr  = 32'h40;
        tick();
        redirect_valid = 1'b0;
        fetch(32'h40, 32'hBBBB_BBBB);
`else
        consume(2'd1);
        chk("no_mtrap", {31'd0, misalign_trap}, 32'd0);
        chk("no_maddr", misalign_addr, 32'h0);
        fetch(32'h100, 32'hBBBB_BBBB);
`endif
        consume(2'd0);
        bus.req_ready = 1'b1;
        tick();
        bus.req_ready = 1'b0;
        rst = 1'b1;
        tick();
        chk("midrst_if_valid", {31'd0, if_valid}, 32'd0);
        chk("midrst_req_valid", {31'd0, bus.req_valid}, 32'd0);
        chk("midrst_if_pc", if_pc, 32'h0);
        rst = 1'b0;
        fetch(32'h0, 32'hCCCC_CCCC);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
